if_predict: RTL and testbench
=============================

IF_PREDICT -- requirements
Module: if_predict

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, BTB depth; power of two, 2..256.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000060, PC value after reset.
REQ-003 SHALL have parameter CTR_INIT, default 2'b01, 2-bit counter value after reset.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port stall  in  1  decode cannot accept; hold presented instruction.
REQ-007 SHALL have port imem_resp  in  1  instruction memory completes the request.
REQ-008 SHALL have port imem_read  out  1  fetch request.
REQ-009 SHALL have port imem_address  out  32  fetch address; equals pc_out.
REQ-010 SHALL have port pc_out  out  32  current fetch PC.
REQ-011 SHALL have port if_valid  out  1  instruction at pc_out is valid for decode.
REQ-012 SHALL have port pred_taken  out  1  prediction for pc_out: BTB hit and counter[1].
REQ-013 SHALL have port pred_target  out  32  predicted next PC (BTB target or pc_out+4).
REQ-014 SHALL have port resolve_valid  in  1  execute resolves a branch/jump this cycle.
REQ-015 SHALL have port resolve_pc  in  32  PC of resolved branch.
REQ-016 SHALL have port resolve_taken  in  1  actual direction.
REQ-017 SHALL have port resolve_target  in  32  actual taken target.
REQ-018 SHALL have port redirect  in  1  mispredict; refetch from redirect_pc.
REQ-019 SHALL have port redirect_pc  in  32  correct next PC; bit 0 cleared on use (JALR rule).

Function
REQ-020 SHALL implement states FETCH, HOLD, DISCARD; imem_read=1 in FETCH and DISCARD, 0 in HOLD.
REQ-021 SHALL keep imem_address stable while imem_read=1 and imem_resp=0.
REQ-022 FETCH, imem_resp=1, stall=0: if_valid=1 same cycle; PC <= pred_target; stay FETCH.
REQ-023 FETCH, imem_resp=1, stall=1: if_valid=1; PC held; go HOLD.
REQ-024 HOLD: if_valid=1; on stall=0, PC <= pred_target, go FETCH; zero-cycle fetch bubble not required.
REQ-025 redirect SHALL have priority over stall and imem_resp in every state.
REQ-026 redirect in FETCH with imem_resp=0: latch {redirect_pc[31:1],1'b0}, go DISCARD; PC held.
REQ-027 redirect in FETCH with imem_resp=1, or in HOLD: PC <= {redirect_pc[31:1],1'b0}, if_valid=0, go FETCH.
REQ-028 DISCARD: if_valid=0; on imem_resp, PC <= latched redirect, go FETCH; later redirect overwrites latch.
REQ-029 BTB SHALL be direct-mapped: index pc[IDX+1:2], tag pc[31:IDX+2], IDX=log2(BTB_ENTRIES); entry = valid, tag, target, 2-bit counter.
REQ-030 Lookup SHALL be combinational on pc_out; pred_target = pc_out+4 (mod 2^32) on miss or counter[1]=0.
REQ-031 On resolve_valid with hit: counter +1 if taken, -1 if not, saturating at 2'b11/2'b00; target <= resolve_target when taken.
REQ-032 On resolve_valid, miss, taken: allocate/replace entry, counter=2'b10; miss, not-taken: no change.
REQ-033 Update SHALL write on the clock edge; same-cycle lookup at same index sees pre-update contents.
REQ-034 pc_out+4 SHALL wrap from 32'hFFFFFFFC to 32'h00000000.

Reset
REQ-035 rst=1 SHALL force PC=RESET_PC, state FETCH, all BTB valid=0, counters=CTR_INIT, latch=0.
REQ-036 During rst=1: imem_read=0, if_valid=0, pred_taken=0; fetch of RESET_PC starts first cycle after rst falls.
REQ-037 rst mid-request or in DISCARD SHALL abandon the request; a late imem_resp is ignored only if it arrives while rst=1.

Verification
REQ-038 Reset, imem_resp every cycle, no stall -> pc_out 0x60,0x64,0x68; if_valid=1 each cycle.
REQ-039 resolve pc=0x68 taken target 0x100 once, refetch 0x68 -> pred_taken=1, pred_target=0x100, next pc_out 0x100.
REQ-040 stall=1 for 3 cycles at pc 0x64 -> pc_out holds 0x64, if_valid=1, imem_read=0 in HOLD; then advances to 0x68.
REQ-041 redirect=1, redirect_pc=0x201 while request pending -> imem_address unchanged until resp, if_valid=0 that resp, next pc_out 0x200.
REQ-042 Four not-taken resolves at a 2'b11 entry -> counter 10,01,00,00; pred_taken drops after the second.
REQ-043 redirect and stall and imem_resp same cycle in FETCH -> redirect wins, if_valid=0, next pc_out = redirect target.

Source files
------------

// File: rtl/if_predict.sv
// Instruction fetch stage with a direct-mapped BTB and 2-bit direction counters.
// Handles imem handshake, decode stall, and execute redirects.
module if_predict #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h00000060,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_resp,
    output logic        imem_read,
    output logic [31:0] imem_address,
    output logic [31:0] pc_out,
    output logic        if_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] latch_q, latch_d;

    logic             btb_valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [31:0]      btb_target_q [BTB_ENTRIES];
    logic [1:0]       btb_ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic [31:0]      pc_plus4;
    logic [31:0]      redir_pc;

    logic [IDX-1:0]   rs_idx;
    logic [TAG_W-1:0] rs_tag;
    logic             rs_hit;
    logic             wr_en;
    logic [31:0]      wr_target;
    logic [1:0]       wr_ctr;
    logic             unused_rs_lo;

    assign unused_rs_lo = ^resolve_pc[1:0];

    // Lookup on the current PC
    assign lk_idx   = pc_q[IDX+1:2];
    assign lk_tag   = pc_q[31:IDX+2];
    assign lk_hit   = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && btb_ctr_q[lk_idx][1];
    assign pc_plus4 = pc_q + 32'd4;
    assign redir_pc = redirect_pc & 32'hFFFF_FFFE;

    assign pred_target  = lk_taken ? btb_target_q[lk_idx] : pc_plus4;
    assign pred_taken   = lk_taken && !rst;
    assign pc_out       = pc_q;
    assign imem_address = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        latch_d   = latch_q;
        imem_read = 1'b0;
        if_valid  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                FETCH: begin
                    imem_read = 1'b1;
                    if (redirect) begin
                        if (imem_resp) begin
                            pc_d = redir_pc;
                        end else begin
                            latch_d = redir_pc;
                            state_d = DISCARD;
                        end
                    end else if (imem_resp) begin
                        if_valid = 1'b1;
                        if (stall) begin
                            state_d = HOLD;
                        end else begin
                            pc_d = pred_target;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_d    = redir_pc;
                        state_d = FETCH;
                    end else begin
                        if_valid = 1'b1;
                        if (!stall) begin
                            pc_d    = pred_target;
                            state_d = FETCH;
                        end
                    end
                end
                DISCARD: begin
                    imem_read = 1'b1;
                    if (redirect) begin
                        if (imem_resp) begin
                            pc_d    = redir_pc;
                            state_d = FETCH;
                        end else begin
                            latch_d = redir_pc;
                        end
                    end else if (imem_resp) begin
                        pc_d    = latch_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Resolve-side update of the indexed entry
    assign rs_idx = resolve_pc[IDX+1:2];
    assign rs_tag = resolve_pc[31:IDX+2];
    assign rs_hit = btb_valid_q[rs_idx] && (btb_tag_q[rs_idx] == rs_tag);

    always_comb begin
        wr_en     = 1'b0;
        wr_target = btb_target_q[rs_idx];
        wr_ctr    = btb_ctr_q[rs_idx];
        if (resolve_valid) begin
            if (rs_hit) begin
                wr_en = 1'b1;
                if (resolve_taken) begin
                    wr_target = resolve_target;
                    if (wr_ctr != 2'b11) wr_ctr = wr_ctr + 2'b01;
                end else begin
                    if (wr_ctr != 2'b00) wr_ctr = wr_ctr - 2'b01;
                end
            end else if (resolve_taken) begin
                wr_en     = 1'b1;
                wr_target = resolve_target;
                wr_ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            latch_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            latch_q <= latch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= 32'h0;
                btb_ctr_q[i]    <= CTR_INIT;
            end
        end else if (wr_en) begin
            btb_valid_q[rs_idx]  <= 1'b1;
            btb_tag_q[rs_idx]    <= rs_tag;
            btb_target_q[rs_idx] <= wr_target;
            btb_ctr_q[rs_idx]    <= wr_ctr;
        end
    end

endmodule

// File: tb/tb_if_predict.sv
// Self-checking bench for if_predict: directed scenarios then random traffic,
// compared every cycle against a behavioural fetch/BTB model.
module tb_if_predict;

    localparam int N    = 16;
    localparam int IDXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        imem_resp;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] pc_out;
    logic        if_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    if_predict dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .imem_resp(imem_resp),
        .imem_read(imem_read),
        .imem_address(imem_address),
        .pc_out(pc_out),
        .if_valid(if_valid),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .resolve_valid(resolve_valid),
        .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: fetch PC, "holding"/"discarding" flags, BTB as arrays
    logic [31:0] m_pc;
    logic [31:0] m_latch;
    bit          m_hold;
    bit          m_disc;
    bit          m_v   [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h60;
        m_latch = 32'h0;
        m_hold  = 0;
        m_disc  = 0;
        for (int i = 0; i < N; i++) begin
            m_v[i]   = 0;
            m_tag[i] = 0;
            m_tgt[i] = 0;
            m_ctr[i] = 1;
        end
    endtask

    task automatic idle();
        stall          = 0;
        imem_resp      = 0;
        resolve_valid  = 0;
        resolve_pc     = 0;
        resolve_taken  = 0;
        resolve_target = 0;
        redirect       = 0;
        redirect_pc    = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic step();
        int          li, ri;
        bit          hit, e_pt_raw, e_read, e_valid, e_pt;
        logic [31:0] e_tgt, n_pc, n_latch, rd;
        bit          n_hold, n_disc;
        #1;
        li       = int'((m_pc >> 2) % N);
        hit      = m_v[li] && (m_tag[li] == (m_pc >> (2 + IDXB)));
        e_pt_raw = hit && (m_ctr[li] >= 2);
        e_tgt    = e_pt_raw ? m_tgt[li] : m_pc + 32'd4;
        e_pt     = e_pt_raw && !rst;
        e_read   = !rst && !m_hold;
        e_valid  = !rst && !redirect && (m_hold || (!m_disc && imem_resp));
        chk("imem_read", 32'(imem_read), 32'(e_read));
        chk("imem_address", imem_address, m_pc);
        chk("pc_out", pc_out, m_pc);
        chk("if_valid", 32'(if_valid), 32'(e_valid));
        chk("pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("pred_target", pred_target, e_tgt);
        n_pc    = m_pc;
        n_latch = m_latch;
        n_hold  = m_hold;
        n_disc  = m_disc;
        rd      = {redirect_pc[31:1], 1'b0};
        if (!rst) begin
            if (redirect) begin
                if (m_hold || imem_resp) begin
                    n_pc   = rd;
                    n_hold = 0;
                    n_disc = 0;
                end else begin
                    n_latch = rd;
                    n_disc  = 1;
                end
            end else if (m_disc) begin
                if (imem_resp) begin
                    n_pc   = m_latch;
                    n_disc = 0;
                end
            end else if (m_hold) begin
                if (!stall) begin
                    n_pc   = e_tgt;
                    n_hold = 0;
                end
            end else if (imem_resp) begin
                if (stall) n_hold = 1;
                else n_pc = e_tgt;
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (resolve_valid) begin
                ri = int'((resolve_pc >> 2) % N);
                if (m_v[ri] && m_tag[ri] == (resolve_pc >> (2 + IDXB))) begin
                    if (resolve_taken) begin
                        m_tgt[ri] = resolve_target;
                        m_ctr[ri] = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
                    end else begin
                        m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
                    end
                end else if (resolve_taken) begin
                    m_v[ri]   = 1;
                    m_tag[ri] = resolve_pc >> (2 + IDXB);
                    m_tgt[ri] = resolve_target;
                    m_ctr[ri] = 2;
                end
            end
            m_pc    = n_pc;
            m_latch = n_latch;
            m_hold  = n_hold;
            m_disc  = n_disc;
        end
        #2;
    endtask

    task automatic resolve(input logic [31:0] p, input bit t,
                           input logic [31:0] tg);
        resolve_valid  = 1;
        resolve_pc     = p;
        resolve_taken  = t;
        resolve_target = tg;
    endtask

    initial begin
        rst = 1;
        idle();
        model_reset();
        @(posedge clk);
        #2;
        step();
        rst = 0;

        // Sequential fetch from reset
        imem_resp = 1;
        settle(); chk("seq0_pc", pc_out, 32'h60);
        chk("seq0_valid", 32'(if_valid), 32'd1);
        step();
        settle(); chk("seq1_pc", pc_out, 32'h64);
        step();
        settle(); chk("seq2_pc", pc_out, 32'h68);
        resolve(32'h68, 1, 32'h100);
        step();
        idle();

        // Refetch 0x68 and follow the prediction
        redirect = 1; redirect_pc = 32'h68; imem_resp = 1;
        step();
        idle(); imem_resp = 1;
        settle(); chk("btb_pt", 32'(pred_taken), 32'd1);
        chk("btb_tgt", pred_target, 32'h100);
        step();
        settle(); chk("btb_pc", pc_out, 32'h100);

        // Stall for three cycles at 0x64
        redirect = 1; redirect_pc = 32'h64;
        step();
        idle(); imem_resp = 1; stall = 1;
        step();
        imem_resp = 0;
        for (int k = 0; k < 2; k++) begin
            settle(); chk("hold_read", 32'(imem_read), 32'd0);
            chk("hold_pc", pc_out, 32'h64);
            chk("hold_valid", 32'(if_valid), 32'd1);
            step();
        end
        stall = 0;
        step();
        settle(); chk("hold_next", pc_out, 32'h68);

        // Redirect while request pending
        redirect = 1; redirect_pc = 32'h201;
        step();
        idle();
        settle(); chk("disc_addr", imem_address, 32'h68);
        chk("disc_read", 32'(imem_read), 32'd1);
        step();
        imem_resp = 1;
        settle(); chk("disc_valid", 32'(if_valid), 32'd0);
        step();
        idle();
        settle(); chk("disc_next", pc_out, 32'h200);

        // Counter walk: 10 -> 11 then four not-taken, then back up
        resolve(32'h200, 1, 32'h300);
        step();
        step();
        idle();
        settle(); chk("ctr11_pt", 32'(pred_taken), 32'd1);
        for (int k = 0; k < 4; k++) begin
            resolve(32'h200, 0, 32'h0);
            step();
            idle();
            settle();
            chk("ctr_dec_pt", 32'(pred_taken), (k == 0) ? 32'd1 : 32'd0);
        end
        resolve(32'h200, 1, 32'h300);
        step();
        idle(); settle(); chk("ctr01_pt", 32'(pred_taken), 32'd0);
        resolve(32'h200, 1, 32'h300);
        step();
        idle(); settle(); chk("ctr10_pt", 32'(pred_taken), 32'd1);

        // Redirect beats stall and response
        redirect = 1; stall = 1; imem_resp = 1; redirect_pc = 32'h400;
        settle(); chk("prio_valid", 32'(if_valid), 32'd0);
        step();
        idle();
        settle(); chk("prio_pc", pc_out, 32'h400);
        chk("prio_read", 32'(imem_read), 32'd1);

        // PC+4 wrap
        redirect = 1; redirect_pc = 32'hFFFF_FFFD; imem_resp = 1;
        step();
        idle(); imem_resp = 1;
        settle(); chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_tgt", pred_target, 32'h0);
        step();
        settle(); chk("wrap_next", pc_out, 32'h0);

        // Reset mid-request, late response during reset
        imem_resp = 0;
        step();
        rst = 1; imem_resp = 1;
        step();
        rst = 0; imem_resp = 0;
        settle(); chk("rst_pc", pc_out, 32'h60);
        chk("rst_read", 32'(imem_read), 32'd1);
        step();

        // Reset while discarding
        redirect = 1; redirect_pc = 32'h500;
        step();
        idle(); rst = 1;
        step();
        rst = 0; imem_resp = 1;
        settle(); chk("rstd_valid", 32'(if_valid), 32'd1);
        chk("rstd_pc", pc_out, 32'h60);
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            imem_resp      = ($urandom_range(0, 9) < 6);
            stall          = ($urandom_range(0, 9) < 3);
            redirect       = ($urandom_range(0, 99) < 8);
            redirect_pc    = 32'($urandom_range(0, 32'h3FF));
            resolve_valid  = ($urandom_range(0, 9) < 4);
            resolve_pc     = 32'($urandom_range(0, 255)) << 2;
            resolve_taken  = ($urandom_range(0, 9) < 6);
            resolve_target = 32'($urandom_range(0, 255)) << 2;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
